// File: rtl/billiard_pkg.sv
// Shared types and table geometry for the billiard ball pipeline.
// Positions are in pixels; velocities are in 1/2^FRAC_BITS pixel per frame.
package billiard_pkg;

    typedef enum logic [1:0] {
        IDLE,
        MOVING,
        SINK
    } ball_state_t;

    typedef logic signed [10:0] velocity_t;

    localparam int FRAC_BITS      = 4;
    localparam int FRICTION       = 1;
    localparam int X_MIN          = 32;
    localparam int X_MAX          = 607;
    localparam int Y_MIN          = 32;
    localparam int Y_MAX          = 447;
    localparam int BALL_SIZE      = 16;
    localparam int INIT_X         = 160;
    localparam int INIT_Y         = 232;
    localparam int RESPAWN_FRAMES = 30;

    localparam velocity_t VEL_NEG_LIMIT = 11'sh400;
    localparam velocity_t VEL_NEG_SAT   = 11'sh401;

    // -1024 has no positive counterpart, so pull it in by one before it is stored.
    function automatic velocity_t sat_vel(input velocity_t v);
        sat_vel = (v == VEL_NEG_LIMIT) ? VEL_NEG_SAT : v;
    endfunction

endpackage

// File: rtl/axis_integrator.sv
// One axis of the ball: fixed-point position, velocity, cushion reflection
// and linear friction, stepped once per update strobe.
module axis_integrator #(
    parameter int FRAC_BITS = 4,
    parameter int FRICTION  = 1,
    parameter int LO        = 32,
    parameter int HI        = 607,
    parameter int SIZE      = 16,
    parameter int INIT      = 160
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               update,
    input  logic               load,
    input  logic signed [10:0] load_vel,
    input  logic               respawn,
    input  logic               halt,
    output logic [10:0]        pos_px,
    output logic signed [10:0] vel,
    output logic               vel_zero_next
);
    import billiard_pkg::*;

    localparam int PW = 11 + FRAC_BITS;
    localparam int AW = PW + 2;

    localparam logic signed [AW-1:0] LO_FX = AW'(LO * (2 ** FRAC_BITS));
    localparam logic signed [AW-1:0] HI_FX = AW'((HI - SIZE) * (2 ** FRAC_BITS));
    localparam logic [PW-1:0]        INIT_FX = PW'(INIT * (2 ** FRAC_BITS));
    localparam velocity_t            FRIC = 11'(FRICTION);

    logic [PW-1:0]         pos_q;
    logic [PW-1:0]         pos_d;
    velocity_t             vel_q;
    velocity_t             vel_d;
    logic signed [AW-1:0]  sum;
    logic signed [AW-1:0]  clamped;
    velocity_t             bounced;
    velocity_t             slowed;

    always_comb begin
        // Two guard bits let an undershoot past the left/top cushion go negative.
        sum     = $signed({2'b00, pos_q}) + AW'(vel_q);
        clamped = sum;
        bounced = vel_q;
        if (sum < LO_FX) begin
            clamped = LO_FX;
            bounced = -vel_q;
        end else if (sum > HI_FX) begin
            clamped = HI_FX;
            bounced = -vel_q;
        end

        slowed = '0;
        if (bounced > FRIC) begin
            slowed = bounced - FRIC;
        end else if (bounced < -FRIC) begin
            slowed = bounced + FRIC;
        end
        vel_zero_next = (slowed == '0);

        pos_d = pos_q;
        vel_d = vel_q;
        if (respawn) begin
            pos_d = INIT_FX;
            vel_d = '0;
        end else if (halt) begin
            vel_d = '0;
        end else if (update) begin
            pos_d = PW'(clamped);
            vel_d = slowed;
        end else if (load) begin
            vel_d = sat_vel(load_vel);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_q <= INIT_FX;
            vel_q <= '0;
        end else begin
            pos_q <= pos_d;
            vel_q <= vel_d;
        end
    end

    assign pos_px = pos_q[PW-1:FRAC_BITS];
    assign vel    = vel_q;

endmodule

// File: rtl/ball_motion_logic.sv
// Cue-ball motion: captures a shot, integrates position every frame,
// sinks the ball on a hole hit and respawns it after a fixed delay.
module ball_motion_logic #(
    parameter int FRAC_BITS      = billiard_pkg::FRAC_BITS,
    parameter int FRICTION       = billiard_pkg::FRICTION,
    parameter int X_MIN          = billiard_pkg::X_MIN,
    parameter int X_MAX          = billiard_pkg::X_MAX,
    parameter int Y_MIN          = billiard_pkg::Y_MIN,
    parameter int Y_MAX          = billiard_pkg::Y_MAX,
    parameter int BALL_SIZE      = billiard_pkg::BALL_SIZE,
    parameter int INIT_X         = billiard_pkg::INIT_X,
    parameter int INIT_Y         = billiard_pkg::INIT_Y,
    parameter int RESPAWN_FRAMES = billiard_pkg::RESPAWN_FRAMES
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               startOfFrame,
    input  logic signed [10:0] newVelocityX,
    input  logic signed [10:0] newVelocityY,
    input  logic               velocityWriteEnable,
    input  logic               holeHit,
    output logic [10:0]        topLeftX,
    output logic [10:0]        topLeftY,
    output logic signed [10:0] velocityX,
    output logic signed [10:0] velocityY,
    output logic               ballMoving,
    output logic               ballSunk
);
    import billiard_pkg::*;

    localparam int CW = $clog2(RESPAWN_FRAMES + 1);

    ball_state_t   state_q;
    ball_state_t   state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          moving_q;
    logic          moving_d;
    logic          sunk_q;
    logic          sunk_d;

    logic          upd;
    logic          load;
    logic          respawn;
    logic          halt;
    logic          zero_x;
    logic          zero_y;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        upd     = 1'b0;
        load    = 1'b0;
        respawn = 1'b0;
        halt    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (velocityWriteEnable) begin
                    load = 1'b1;
                    if (newVelocityX != '0 || newVelocityY != '0) begin
                        state_d = MOVING;
                    end
                end
            end
            MOVING: begin
                if (holeHit) begin
                    halt    = 1'b1;
                    cnt_d   = '0;
                    state_d = SINK;
                end else if (startOfFrame) begin
                    upd = 1'b1;
                    if (zero_x && zero_y) begin
                        state_d = IDLE;
                    end
                end
            end
            SINK: begin
                halt = 1'b1;
                if (startOfFrame) begin
                    if (cnt_q == CW'(RESPAWN_FRAMES - 1)) begin
                        respawn = 1'b1;
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        moving_d = (state_d == MOVING);
        sunk_d   = (state_d == SINK);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            moving_q <= 1'b0;
            sunk_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            moving_q <= moving_d;
            sunk_q   <= sunk_d;
        end
    end

    axis_integrator #(
        .FRAC_BITS (FRAC_BITS),
        .FRICTION  (FRICTION),
        .LO        (X_MIN),
        .HI        (X_MAX),
        .SIZE      (BALL_SIZE),
        .INIT      (INIT_X)
    ) u_axis_x (
        .clk           (clk),
        .reset         (reset),
        .update        (upd),
        .load          (load),
        .load_vel      (newVelocityX),
        .respawn       (respawn),
        .halt          (halt),
        .pos_px        (topLeftX),
        .vel           (velocityX),
        .vel_zero_next (zero_x)
    );

    axis_integrator #(
        .FRAC_BITS (FRAC_BITS),
        .FRICTION  (FRICTION),
        .LO        (Y_MIN),
        .HI        (Y_MAX),
        .SIZE      (BALL_SIZE),
        .INIT      (INIT_Y)
    ) u_axis_y (
        .clk           (clk),
        .reset         (reset),
        .update        (upd),
        .load          (load),
        .load_vel      (newVelocityY),
        .respawn       (respawn),
        .halt          (halt),
        .pos_px        (topLeftY),
        .vel           (velocityY),
        .vel_zero_next (zero_y)
    );

    assign ballMoving = moving_q;
    assign ballSunk   = sunk_q;

endmodule
